dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the memory-stage data port. Accepts load/store requests from the pipeline's
//  memory stage over a valid/ready handshake, inserts programmable wait states, then performs a
//  byte-lane-masked access to on-chip data RAM. Returns sign/zero-extended load data and an error
//  flag. Sits between the memory stage and the data RAM; replaces the zero-wait combinational dmem.
// PARAMETERS
//  DEPTH_WORDS  1024  32-bit words of RAM; power of two
//  WAIT_STATES  1     extra cycles between accept and RAM access; 0..15
//  BASE_ADDR    32'h0 byte address of word 0; other addresses are out of range
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous assert, active-low (0 = reset)
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned
//  req_size     in   2   0 = byte, 1 = half, 2 = word; 3 = reserved (error)
//  req_unsigned in   1   loads: 1 = zero-extend, 0 = sign-extend
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   requester takes response
//  rsp_rdata    out  32  extended load data; 0 for stores and errors
//  rsp_err      out  1   out of range, reserved size or misaligned (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    RAM contents are not reset. Reset mid-transaction aborts it; a store not yet committed is lost.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. req_ready=1 only in IDLE.
//  - IDLE: if req_valid, capture all req_* fields. Go to WAIT if WAIT_STATES>0; otherwise go
//    straight to RESP and perform the RAM access on that same edge.
//  - WAIT: counter counts from 0. The RAM access happens on the edge where counter==WAIT_STATES-1,
//    which is also the edge into RESP.
//  - RAM access: a store writes byte enables from size and addr[1:0] (byte: 1<<a; half: 3<<a;
//    word: 4'hF), with data replicated across lanes. Loads read the full word.
//  - Erroring requests never write. They return rsp_err=1 and rsp_rdata=0.
//  - RESP: rsp_valid=1 and outputs are held stable until rsp_ready. Return to IDLE on
//    rsp_valid&&rsp_ready. There is no accept in the same cycle: throughput is one request
//    per WAIT_STATES+2 cycles minimum.
//  - Latency: accept edge to rsp_valid is WAIT_STATES+1 cycles.
//  - Load extension: the byte or half is selected by addr[1:0] and extended to 32 bits
//    per req_unsigned. A word is passed through.
//  - Word index = (addr-BASE_ADDR)>>2. In range iff addr>=BASE_ADDR and index<DEPTH_WORDS.
//    Address wrap-around is an error, not an aliased access.
//  - Changes on req_* while req_ready=0 are ignored.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined:
//    half with addr[0]!=0, or word with addr[1:0]!=0 -> rsp_err=1, no write.
//  DMEM_MISALIGN_TRAP_EN undefined:
//    low address bits below the access size are forced to 0 (access aligned down), rsp_err
//    only for out of range or reserved size.
// STRUCTURE
//  Package dmem_pkg holds:
//    - typedef enum logic [1:0] mem_size_e {SZ_B, SZ_H, SZ_W, SZ_RSV}
//    - typedef enum logic [1:0] dmem_state_e {IDLE, WAIT, RESP}
//    - function byte_en(size, addr_lo)
//    - function load_ext(word, size, addr_lo, uns)
//  Sub-module dmem_sram_array(clk, we, be[3:0], idx, wdata, rdata): synchronous read,
//  byte-enable write, DEPTH_WORDS parameter, no reset.
// TESTING
//  1. Reset during WAIT (WAIT_STATES=3): store to 0x10 accepted, rst low for 1 cycle ->
//     rsp_valid=0, req_ready=1, later load 0x10 returns the prior contents.
//  2. WAIT_STATES=1:
//     - SW 0xDEADBEEF @0x8 -> rsp_valid 2 cycles after accept, rsp_rdata=0, rsp_err=0
//     - then LW @0x8 -> 0xDEADBEEF
//  3. After test 2's store, LB @0xB -> 0xFFFFFFDE, LBU @0xB -> 0x000000DE,
//     LH @0xA -> 0xFFFFDEAD, LHU @0x8 -> 0x0000BEEF.
//  4. SB 0x12345677 @0x9 over 0xDEADBEEF -> LW @0x8 = 0xDEAD77EF (only lane 1 written).
//  5. Out of range (DEPTH_WORDS=1024): SW @0x1000 -> rsp_err=1, rdata 0, no write.
//     Size 3 -> rsp_err=1. Misaligned LW @0x6:
//     - with macro: rsp_err=1
//     - without macro: returns word @0x4, rsp_err=0
//  6. Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout,
//     next request accepted the cycle after the handshake.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   mem_size_e   - access size encoding carried on req_size
//   dmem_state_e - responder FSM states
//   dmem_req_t   - captured request fields
//   byte_en()    - store byte-lane enables from size and low address bits
//   load_ext()   - lane select plus sign/zero extension for loads
package dmem_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} mem_size_e;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      mem_size_e   size;
      logic        uns;
   } dmem_req_t;

   function automatic logic [3:0] byte_en(mem_size_e size, logic [1:0] addr_lo);
      case (size)
         SZ_B:    return 4'b0001 << addr_lo;
         SZ_H:    return 4'b0011 << addr_lo;
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(logic [31:0] word, mem_size_e size,
                                            logic [1:0] addr_lo, logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{addr_lo, 3'b000} +: 8];
      h = word[{addr_lo[1], 4'b0000} +: 16];
      case (size)
         SZ_B:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_H:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: memory-stage data port bundle.
//   req_*  request channel (valid/ready), driven by the memory stage
//   rsp_*  response channel (valid/ready), driven by the responder
// modport master = memory stage, modport slave = responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_sram_array.sv
// dmem_sram_array: DEPTH_WORDS x 32 data RAM, byte-lane write enables,
// synchronous read (rdata valid the cycle after idx is presented). No reset.
//   clk   clock
//   we    write strobe, qualified per lane by be
//   be    byte enables, bit i writes wdata[8i+7:8i]
//   idx   word index
//   wdata write data (already lane-replicated by the caller)
//   rdata registered read data of mem[idx]
module dmem_sram_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [IW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [3:0][7:0] mem [DEPTH_WORDS];

   for (genvar l = 0; l < 4; l++) begin : g_lane
      always_ff @(posedge clk) begin
         if (we && be[l]) mem[idx][l] <= wdata[8*l +: 8];
      end
   end

   // Read-before-write: a same-edge write is not visible until the next read.
   always_ff @(posedge clk) begin
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the memory-stage data port.
// Accepts one load/store over bus.req_*, waits WAIT_STATES cycles, performs a
// byte-masked access to dmem_sram_array, then holds the response on bus.rsp_*
// until taken.
//   clk  clock, all state on rising edge
//   rst  asynchronous reset, active low
//   bus  dmem_responder_if.slave (request and response channels)
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses report
// rsp_err instead of being aligned down.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);

   localparam int          IW       = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH32  = 32'(DEPTH_WORDS);
   localparam logic [3:0]  CNT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   dmem_state_e state, state_n;
   logic [3:0]  cnt, cnt_n;
   dmem_req_t   cap, live, acc;
   logic        cap_ld;
   logic        fire;

   // Decode of the request being worked on
   logic [31:0] off, word_off;
   logic        in_range, misal, acc_err;
   logic [1:0]  lo;
   logic [31:0] wdata_rep;

   // RAM port
   logic          ram_we;
   logic [3:0]    ram_be;
   logic [IW-1:0] ram_idx;
   logic [31:0]   ram_rdata;

   always_comb begin
      live.we    = bus.req_we;
      live.addr  = bus.req_addr;
      live.wdata = bus.req_wdata;
      live.size  = mem_size_e'(bus.req_size);
      live.uns   = bus.req_unsigned;
   end

   // In IDLE the live request is decoded so a zero-wait access can fire on the
   // accept edge; afterwards the captured copy is used so req_* may change.
   assign acc = (state == IDLE) ? live : cap;

   always_comb begin
      off      = acc.addr - BASE_ADDR;
      word_off = off >> 2;
      // addr < BASE_ADDR would wrap off to a large value; reject it explicitly.
      in_range = (acc.addr >= BASE_ADDR) && (word_off < DEPTH32);
`ifdef DMEM_MISALIGN_TRAP_EN
      misal = ((acc.size == SZ_H) && acc.addr[0]) ||
              ((acc.size == SZ_W) && (acc.addr[1:0] != 2'b00));
      lo    = acc.addr[1:0];
`else
      misal = 1'b0;
      case (acc.size)
         SZ_H:    lo = {acc.addr[1], 1'b0};
         SZ_W:    lo = 2'b00;
         default: lo = acc.addr[1:0];
      endcase
`endif
      acc_err = !in_range || (acc.size == SZ_RSV) || misal;
      case (acc.size)
         SZ_B:    wdata_rep = {4{acc.wdata[7:0]}};
         SZ_H:    wdata_rep = {2{acc.wdata[15:0]}};
         default: wdata_rep = acc.wdata;
      endcase
   end

   assign ram_we  = fire && acc.we && !acc_err;
   assign ram_be  = byte_en(acc.size, lo);
   assign ram_idx = word_off[IW-1:0];

   dmem_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (ram_be),
      .idx   (ram_idx),
      .wdata (wdata_rep),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         cap   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (cap_ld) cap <= live;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cap_ld  = 1'b0;
      fire    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               cap_ld = 1'b1;
               cnt_n  = '0;
               if (WAIT_STATES == 0) begin
                  fire    = 1'b1;
                  state_n = RESP;
               end else begin
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == CNT_LAST) begin
               fire    = 1'b1;
               cnt_n   = '0;
               state_n = RESP;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // The RAM keeps re-reading the captured index during RESP and is not written
   // there, so the response stays stable under backpressure.
   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      bus.rsp_err   = (state == RESP) && acc_err;
      bus.rsp_rdata = '0;
      if ((state == RESP) && !acc_err && !cap.we)
         bus.rsp_rdata = load_ext(ram_rdata, cap.size, lo, cap.uns);
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed test of dmem_responder.
// dut_a: WAIT_STATES=1 for functional vectors; dut_b: WAIT_STATES=3 for the
// reset-during-wait case.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   dmem_responder_if ia ();
   dmem_responder_if ib ();

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut_a (
      .clk(clk), .rst(rst_a), .bus(ia.slave));
   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut_b (
      .clk(clk), .rst(rst_b), .bus(ib.slave));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns);
      if (sel) begin
         ib.req_valid = v; ib.req_we = we; ib.req_addr = addr;
         ib.req_wdata = wdata; ib.req_size = size; ib.req_unsigned = uns;
      end else begin
         ia.req_valid = v; ia.req_we = we; ia.req_addr = addr;
         ia.req_wdata = wdata; ia.req_size = size; ia.req_unsigned = uns;
      end
   endtask

   task automatic set_rr(input bit sel, input logic v);
      if (sel) ib.rsp_ready = v; else ia.rsp_ready = v;
   endtask

   function automatic logic        rv (input bit sel); return sel ? ib.rsp_valid : ia.rsp_valid; endfunction
   function automatic logic        rdy(input bit sel); return sel ? ib.req_ready : ia.req_ready; endfunction
   function automatic logic [31:0] rda(input bit sel); return sel ? ib.rsp_rdata : ia.rsp_rdata; endfunction
   function automatic logic        rer(input bit sel); return sel ? ib.rsp_err   : ia.rsp_err;   endfunction

   // One transaction: present at a negedge, accept on the next posedge, then
   // scramble req_* while busy. hold>0 keeps rsp_ready low for hold cycles of RESP.
   task automatic xact(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input int hold, output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      chk("req_ready before accept", 32'(rdy(sel)), 32'd1);
      chk("rsp_valid before accept", 32'(rv(sel)), 32'd0);
      drive(sel, 1'b1, we, addr, wdata, size, uns);
      set_rr(sel, hold == 0);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 2'd2, 1'b0);
      lat = 1;
      while (!rv(sel) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_valid arrives", 32'(rv(sel)), 32'd1);
      rd = rda(sel);
      er = rer(sel);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp rsp_valid", 32'(rv(sel)), 32'd1);
         chk("bp rsp_rdata", rda(sel), rd);
         chk("bp rsp_err",   32'(rer(sel)), 32'(er));
         chk("bp req_ready", 32'(rdy(sel)), 32'd0);
      end
      set_rr(sel, 1'b1);
      @(posedge clk);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      set_rr(0, 1'b1);
      set_rr(1, 1'b1);
      repeat (2) @(negedge clk);
      chk("reset req_ready", 32'(ia.req_ready), 32'd1);
      chk("reset rsp_valid", 32'(ia.rsp_valid), 32'd0);
      chk("reset rsp_rdata", ia.rsp_rdata, 32'h0);
      chk("reset rsp_err",   32'(ia.rsp_err), 32'd0);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Store then load back, latency check
      xact(0, 1, 32'h8, 32'hDEADBEEF, 2'd2, 0, 0, rd, er, lat);
      chk("SW latency", 32'(lat), 32'd2);
      chk("SW rdata", rd, 32'h0);
      chk("SW err", 32'(er), 32'd0);
      xact(0, 0, 32'h8, 32'h0, 2'd2, 0, 0, rd, er, lat);
      chk("LW 0x8", rd, 32'hDEADBEEF);
      chk("LW 0x8 err", 32'(er), 32'd0);

      // Sub-word loads with extension
      xact(0, 0, 32'hB, 32'h0, 2'd0, 0, 0, rd, er, lat);
      chk("LB 0xB", rd, 32'hFFFFFFDE);
      xact(0, 0, 32'hB, 32'h0, 2'd0, 1, 0, rd, er, lat);
      chk("LBU 0xB", rd, 32'h000000DE);
      xact(0, 0, 32'hA, 32'h0, 2'd1, 0, 0, rd, er, lat);
      chk("LH 0xA", rd, 32'hFFFFDEAD);
      xact(0, 0, 32'h8, 32'h0, 2'd1, 1, 0, rd, er, lat);
      chk("LHU 0x8", rd, 32'h0000BEEF);

      // Byte store touches only lane 1
      xact(0, 1, 32'h9, 32'h12345677, 2'd0, 0, 0, rd, er, lat);
      chk("SB err", 32'(er), 32'd0);
      xact(0, 0, 32'h8, 32'h0, 2'd2, 0, 0, rd, er, lat);
      chk("LW after SB", rd, 32'hDEAD77EF);

      // Out of range: must error and not alias onto word 0
      xact(0, 1, 32'h0, 32'h11111111, 2'd2, 0, 0, rd, er, lat);
      xact(0, 1, 32'h1000, 32'h00000BAD, 2'd2, 0, 0, rd, er, lat);
      chk("SW oor err", 32'(er), 32'd1);
      chk("SW oor rdata", rd, 32'h0);
      xact(0, 0, 32'h0, 32'h0, 2'd2, 0, 0, rd, er, lat);
      chk("LW 0x0 after oor", rd, 32'h11111111);
      xact(0, 0, 32'hFFFF_FFFC, 32'h0, 2'd2, 0, 0, rd, er, lat);
      chk("LW top-of-space err", 32'(er), 32'd1);

      // Reserved size: error, no write
      xact(0, 0, 32'h8, 32'h0, 2'd3, 0, 0, rd, er, lat);
      chk("size3 load err", 32'(er), 32'd1);
      chk("size3 load rdata", rd, 32'h0);
      xact(0, 1, 32'h8, 32'h0, 2'd3, 0, 0, rd, er, lat);
      chk("size3 store err", 32'(er), 32'd1);
      xact(0, 0, 32'h8, 32'h0, 2'd2, 0, 0, rd, er, lat);
      chk("LW 0x8 after size3 store", rd, 32'hDEAD77EF);

      // Misaligned word load
      xact(0, 1, 32'h4, 32'hCAFEF00D, 2'd2, 0, 0, rd, er, lat);
      xact(0, 0, 32'h6, 32'h0, 2'd2, 0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("LW 0x6 err", 32'(er), 32'd1);
      chk("LW 0x6 rdata", rd, 32'h0);
`else
      chk("LW 0x6 err", 32'(er), 32'd0);
      chk("LW 0x6 rdata", rd, 32'hCAFEF00D);
`endif

      // Backpressure, then back-to-back accept right after the handshake
      xact(0, 0, 32'h8, 32'h0, 2'd2, 0, 5, rd, er, lat);
      chk("bp LW 0x8", rd, 32'hDEAD77EF);
      xact(0, 0, 32'h8, 32'h0, 2'd0, 1, 0, rd, er, lat);
      chk("LBU 0x8 after bp", rd, 32'h000000EF);

      // dut_b: reset while a store sits in WAIT drops the store
      xact(1, 1, 32'h10, 32'h5A5A5A5A, 2'd2, 0, 0, rd, er, lat);
      chk("WS3 latency", 32'(lat), 32'd4);
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 32'h10, 32'h00000000, 2'd2, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      chk("WS3 in wait", 32'(ib.req_ready), 32'd0);
      rst_b = 1'b0;
      #1;
      chk("reset mid rsp_valid", 32'(ib.rsp_valid), 32'd0);
      chk("reset mid req_ready", 32'(ib.req_ready), 32'd1);
      @(negedge clk);
      rst_b = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post-reset no rsp", 32'(ib.rsp_valid), 32'd0);
      end
      xact(1, 0, 32'h10, 32'h0, 2'd2, 0, 0, rd, er, lat);
      chk("LW 0x10 after abort", rd, 32'h5A5A5A5A);
      chk("LW 0x10 err", 32'(er), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
